// File: rtl/pingpong_buf_ctrl.sv
// Write/read sequencer for the two-bank ping-pong RAM behind the SPI slave receiver.
// Fills the active bank, hands closed banks to the reader, and drops bytes when no bank is free.
module pingpong_buf_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              frame_end,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              bank_rdy,
  output logic              rd_bank,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_done,
  output logic              overflow,
  input  logic              clr_ovf
);

  // state  | meaning
  // W_FILL | accepting bytes into wr_bank
  // W_WAIT | wr_bank still held by the reader; incoming bytes are dropped
  typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wstate_t;

  wstate_t           state, state_nxt;
  logic              wr_bank;
  logic              rd_ptr;
  logic [ADDR_W-1:0] wr_cnt;
  logic [1:0]        bank_full, bank_full_nxt;
  logic [ADDR_W:0]   len0, len1;
  logic [ADDR_W:0]   close_len;
  logic              accept, drop, close, rd_rel;

  assign rd_rel  = rd_done & bank_rdy;
  assign rd_bank = rd_ptr;
  assign rd_len  = rd_ptr ? len1 : len0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W_FILL;
    else        state <= state_nxt;
  end

  // A bank released this cycle counts as free, so close+rd_done never enters W_WAIT.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rd_rel) bank_full_nxt[rd_ptr]  = 1'b0;
    if (close)  bank_full_nxt[wr_bank] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_FILL: if (close && bank_full_nxt[!wr_bank]) state_nxt = W_WAIT;
      W_WAIT: if (!bank_full[wr_bank]) state_nxt = W_FILL;
      default: state_nxt = W_FILL;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    drop      = 1'b0;
    close     = 1'b0;
    close_len = {1'b0, wr_cnt} + (ADDR_W+1)'(byte_valid);
    case (state)
      W_FILL: begin
        accept = byte_valid;
        close  = (byte_valid && wr_cnt == ADDR_W'(DEPTH-1)) ||
                 (frame_end && (wr_cnt != '0 || byte_valid));
      end
      W_WAIT: drop = byte_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_ptr    <= 1'b0;
      bank_full <= 2'b00;
      bank_rdy  <= 1'b0;
      len0      <= '0;
      len1      <= '0;
      overflow  <= 1'b0;
    end else begin
      ram_we    <= accept;
      if (accept) begin
        ram_waddr <= {wr_bank, wr_cnt};
        ram_wdata <= byte_data;
      end
      if (close) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
        if (wr_bank) len1 <= close_len;
        else         len0 <= close_len;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      bank_full <= bank_full_nxt;
      if (rd_rel) rd_ptr <= !rd_ptr;
      // Forced low on release so the reader always sees a gap between banks.
      bank_rdy  <= rd_rel ? 1'b0 : bank_full[rd_ptr];
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
